// File: rtl/fp32_mult_dispatcher.sv
// Operand FIFO and job sequencer in front of the fp32 multiplier.
// One job in flight; results held until the consumer takes them.
module fp32_mult_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   in_a_i,
    input  logic [31:0]   in_b_i,
    output logic          mul_start_o,
    output logic [31:0]   mul_a_o,
    output logic [31:0]   mul_b_o,
    input  logic [31:0]   mul_product_i,
    input  logic          mul_done_i,
    input  logic          mul_nan_i,
    input  logic          mul_infinit_i,
    input  logic          mul_overflow_i,
    input  logic          mul_underflow_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [31:0]   res_product_o,
    output logic [4:0]    res_flags_o,
    output logic          busy_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t        r_state;
    logic [31:0]   r_mem_a [DEPTH];
    logic [31:0]   r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tcnt;
    logic          r_done_q;
    logic          r_start;
    logic [31:0]   r_mul_a;
    logic [31:0]   r_mul_b;
    logic          r_res_valid;
    logic [31:0]   r_res_product;
    logic [4:0]    r_res_flags;

    logic w_push;
    logic w_pop;
    logic w_done_rise;

    assign in_ready_o  = (r_count < CW'(DEPTH));
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0)
                         && !r_res_valid;
    // Only a fresh 0->1 edge counts, so a done left high is ignored
    assign w_done_rise = mul_done_i && !r_done_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a_i;
            r_mem_b[r_wr_ptr] <= in_b_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tcnt        <= '0;
            r_done_q      <= 1'b0;
            r_start       <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
            r_res_flags   <= '0;
        end else begin
            r_done_q <= mul_done_i;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_mul_a <= r_mem_a[r_rd_ptr];
                        r_mul_b <= r_mem_b[r_rd_ptr];
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        r_res_product <= mul_product_i;
                        r_res_flags   <= {1'b0, mul_nan_i,
                                          mul_infinit_i,
                                          mul_overflow_i,
                                          mul_underflow_i};
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESULT;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_res_product <= 32'h7FC0_0000;
                        r_res_flags   <= 5'b10000;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESULT;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_start_o   = r_start;
    assign mul_a_o       = r_mul_a;
    assign mul_b_o       = r_mul_b;
    assign res_valid_o   = r_res_valid;
    assign res_product_o = r_res_product;
    assign res_flags_o   = r_res_flags;
    assign busy_o        = (r_state != S_IDLE) || (r_count != '0);
    assign count_o       = r_count;

endmodule
